// File: rtl/audio_pwm_out.sv
// audio_pwm_out: 1-entry sample holding register feeding a frame-aligned PWM pad driver.
// Define AUDIO_PWM_SDM_EN to replace the PWM comparator with a first-order sigma-delta modulator.
module audio_pwm_out #(
    parameter int                DATA_W   = 8,
    parameter int                PRESCALE = 4,
    parameter logic [DATA_W-1:0] RST_DUTY = {1'b1, {(DATA_W-1){1'b0}}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              pwm_out,
    output logic              frame_start,
    output logic              underrun
);

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]     pre;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] duty;
    logic [DATA_W-1:0] hold;
    logic              hold_full;
    logic              tick;
    logic              wrap;
    logic              xfer;

    assign tick     = (pre == PRE_MAX);
    assign wrap     = tick && (&cnt);
    assign in_ready = rst_n && !hold_full;
    assign xfer     = in_valid && in_ready;

    // Prescaler: one tick every PRESCALE clocks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Frame counter: advances per tick, wraps naturally at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + DATA_W'(1);
        end
    end

    // Holding register and frame-boundary duty load; load decision uses pre-edge hold_full
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold        <= '0;
            hold_full   <= 1'b0;
            duty        <= RST_DUTY;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= wrap;
            underrun    <= wrap && !hold_full;
            if (wrap && hold_full) begin
                duty      <= hold;
                hold_full <= 1'b0;
            end
            if (xfer) begin
                hold      <= in_sample;
                hold_full <= 1'b1;
            end
        end
    end

`ifdef AUDIO_PWM_SDM_EN
    logic [DATA_W:0] acc;

    // Sigma-delta accumulator: carry out is the modulator bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (tick) begin
            acc <= {1'b0, acc[DATA_W-1:0]} + {1'b0, duty};
        end
    end

    // Registered modulator output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= acc[DATA_W];
        end
    end
`else
    // Registered PWM comparator: high while cnt is below duty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (cnt < duty);
        end
    end
`endif

endmodule

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out: scoreboard bench for audio_pwm_out (PRESCALE=1, DATA_W=8).
// Expected per-frame high counts are queued at transfer time and compared per measured frame.
module tb_audio_pwm_out;

    localparam int FRAME = 256;
    localparam int RSTD  = 128;
`ifdef AUDIO_PWM_SDM_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_sample = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       pwm_out;
    logic       frame_start;
    logic       underrun;

    audio_pwm_out #(
        .DATA_W  (8),
        .PRESCALE(1),
        .RST_DUTY(8'h80)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pwm_out    (pwm_out),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int t;
    } sb_t;

    typedef struct {
        logic [7:0] s;
        int         e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rst_q = 1'b0;
    sb_t  sq[$];

    int   last_duty = RSTD;
    int   last_fs = 0;
    bit   fs_ok = 0;
    int   ev_p[LAT];
    int   ex_p[LAT];
    bit   active = 0;
    int   cur_exp = 0;
    int   ones = 0;
    bit   und_exp;
    int   e;
    bit   prev_pwm = 0;
    bit   consec = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    always @(posedge clk) begin
        rst_q <= rst_n;
        cyc   <= cyc + 1;
    end

    initial begin
        for (int i = 0; i < LAT; i++) begin
            ev_p[i] = 0;
            ex_p[i] = 0;
        end
    end

    // Frame monitor: predicts underrun, checks frame spacing, measures high count
    always @(negedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            ev_p[i] = ev_p[i-1];
            ex_p[i] = ex_p[i-1];
        end
        ev_p[0] = 0;
        ex_p[0] = 0;
        if (!rst_q) begin
            sq.delete();
            last_duty = RSTD;
            last_fs   = cyc;
            fs_ok     = 1;
            ev_p[0]   = 2;
            ex_p[0]   = RSTD;
        end else if (frame_start === 1'b1) begin
            und_exp = !(sq.size() > 0 && sq[0].t < cyc);
            chk("underrun", int'(underrun), int'(und_exp));
            if (fs_ok) chk("frame_len", cyc - last_fs, FRAME);
            last_fs = cyc;
            if (und_exp) begin
                e = last_duty;
            end else begin
                e = sq.pop_front().v;
                last_duty = e;
            end
            ev_p[0] = 1;
            ex_p[0] = e;
        end else if (underrun === 1'b1) begin
            chk("underrun_no_frame", int'(underrun), 0);
        end
        if (ev_p[LAT-1] != 0) begin
            if (active && ev_p[LAT-1] == 1) begin
                chk("high_count", ones, cur_exp);
`ifdef AUDIO_PWM_SDM_EN
                if (cur_exp <= 128) chk("sdm_consec", int'(consec), 0);
`endif
            end
            active   = 1;
            cur_exp  = ex_p[LAT-1];
            ones     = 0;
            prev_pwm = 0;
            consec   = 0;
        end
        if (active) begin
            if (pwm_out === 1'b1) begin
                ones++;
                if (prev_pwm) consec = 1;
            end
            prev_pwm = (pwm_out === 1'b1);
        end
    end

    task automatic push(input logic [7:0] s, input int exp);
        bit done;
        done      = 0;
        in_sample = s;
        in_valid  = 1'b1;
        for (int n = 0; n < 600 && !done; n++) begin
            if (in_ready) begin
                sq.push_back('{v: exp, t: cyc + 1});
                done = 1;
            end
            @(negedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) timeout("push");
    endtask

    task automatic wait_fs();
        bit done;
        done = 0;
        for (int n = 0; n < 600 && !done; n++) begin
            @(negedge clk);
            #1;
            if (frame_start) done = 1;
        end
        if (!done) timeout("wait_frame");
    endtask

    task automatic wait_cnt(input int c);
        bit done;
        done = 0;
        for (int n = 0; n < 600 && !done; n++) begin
            @(negedge clk);
            #1;
            if ((cyc - last_fs) % FRAME == c) done = 1;
        end
        if (!done) timeout("wait_cnt");
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{s: 8'h40, e: 64};
        vt[1] = '{s: 8'h00, e: 0};
        vt[2] = '{s: 8'hFF, e: 255};
        vt[3] = '{s: 8'h01, e: 1};
        vt[4] = '{s: 8'h80, e: 128};
        vt[5] = '{s: 8'hFE, e: 254};
        vt[6] = '{s: 8'h20, e: 32};
        vt[7] = '{s: 8'h30, e: 48};

        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", int'(in_ready), 1);

        wait_cnt(10);
        push(8'h40, 64);
        chk("ready_drop", int'(in_ready), 0);
        wait_fs();
        chk("ready_after_load", int'(in_ready), 1);

        push(8'h20, 32);
        push(8'h30, 48);
        chk("stall_accept_cnt", (cyc - last_fs) % FRAME, 1);
        chk("ready_after_stall", int'(in_ready), 0);
        wait_fs();
        wait_fs();
        wait_fs();

        foreach (vt[i]) begin
            push(vt[i].s, vt[i].e);
            chk("vec_ready", int'(in_ready), 0);
        end
        wait_fs();
        wait_fs();

        push(8'h10, 16);
        wait_cnt(100);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_ready", int'(in_ready), 0);
        chk("mid_rst_frame_start", int'(frame_start), 0);
        rst_n = 1'b1;
        wait_fs();
        wait_fs();
        repeat (LAT + 2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
